// File: rtl/html_layout_engine.sv
// html_layout_engine: nested style/box context stack turning markup events into rect and glyph draw commands.
// Define LAYOUT_WRAP_EN to wrap text at the box's right edge instead of suppressing overflowing glyphs.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 2
`endif
`ifndef TAG_BODY
`define TAG_BODY 2'd0
`endif
`ifndef TAG_P
`define TAG_P 2'd1
`endif
`ifndef TAG_DIV
`define TAG_DIV 2'd2
`endif
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATT_COLOR
`define ATT_COLOR 4'd0
`define ATT_SIZE 4'd1
`define ATT_WIDTH 4'd2
`define ATT_HEIGHT 4'd3
`define ATT_BG 4'd4
`define ATT_MARGIN 4'd5
`define ATT_PADDING 4'd6
`define ATT_BORDER 4'd7
`endif

module html_layout_engine #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int COLOR_W = 3,
    parameter int VAL_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int FONT_W = 5,
    parameter int FONT_H = 7,
    parameter int KERNING = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             evt_valid,
    output logic                             evt_ready,
    input  logic [1:0]                       evt_kind,
    input  logic [`ELE_TAG_BITES-1:0]        evt_tag,
    input  logic [`ATTRIBUTE_TYPE_BITES-1:0] evt_attr_type,
    input  logic [VAL_W-1:0]                 evt_attr_value,
    input  logic [7:0]                       evt_char,
    output logic                             rect_valid,
    input  logic                             rect_ready,
    output logic [X_W-1:0]                   rect_x,
    output logic [Y_W-1:0]                   rect_y,
    output logic [X_W-1:0]                   rect_w,
    output logic [Y_W-1:0]                   rect_h,
    output logic [COLOR_W-1:0]               rect_bg,
    output logic [COLOR_W-1:0]               rect_border_color,
    output logic                             rect_has_border,
    output logic                             glyph_valid,
    input  logic                             glyph_ready,
    output logic [7:0]                       glyph_char,
    output logic [X_W-1:0]                   glyph_x,
    output logic [Y_W-1:0]                   glyph_y,
    output logic [VAL_W-1:0]                 glyph_size,
    output logic [COLOR_W-1:0]               glyph_color,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             err_overflow,
    output logic                             err_underflow
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;
    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, APPLY, EMIT_RECT, EMIT_GLYPH, POP} state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [VAL_W-1:0]   size;
        logic [X_W-1:0]     bx;
        logic [Y_W-1:0]     by;
        logic [X_W-1:0]     bw;
        logic [Y_W-1:0]     bh;
        logic [VAL_W-1:0]   margin;
        logic [VAL_W-1:0]   padding;
        logic [COLOR_W-1:0] bg;
        logic               border_en;
        logic [COLOR_W-1:0] border_color;
        logic [XW1-1:0]     cx;
        logic [YW1-1:0]     cy;
    } ctx_t;

    function automatic ctx_t strip(input ctx_t c);
        ctx_t r = c;
        r.margin = '0;
        r.padding = '0;
        r.bw = '0;
        r.bh = '0;
        return r;
    endfunction

    state_t state;
    ctx_t cur, pend, child, par, root;
    ctx_t stk [0:(1<<DW)-1];
    logic [`ELE_TAG_BITES-1:0] tag_stk [0:(1<<DW)-1];
    logic [`ELE_TAG_BITES-1:0] op_tag;
    logic [7:0] dropped;
    logic [DW-1:0] top_i;
    logic [XW1-1:0] sw, adv, right, dx, gx;
    logic [YW1-1:0] sh, bot, gy;
    logic draw_rect, glyph_ok;

    assign evt_ready = state == IDLE && !reset;
    assign top_i = depth - 1'b1;

    always_comb begin
        root = '0;
        root.color = COLOR_W'(7);
        root.size = VAL_W'(1);
        root.bw = X_W'(SCREEN_W);
        root.bh = Y_W'(SCREEN_H);
        sw = XW1'(cur.size) * XW1'(FONT_W);
        adv = XW1'(cur.size) * XW1'(FONT_W + KERNING);
        sh = YW1'(cur.size) * YW1'(FONT_H);
        right = XW1'(cur.bx) + XW1'(cur.bw) - XW1'(cur.padding);
        bot = YW1'(cur.by) + YW1'(cur.bh);
        gx = cur.cx;
        gy = cur.cy;
`ifdef LAYOUT_WRAP_EN
        if (gx + sw > right) begin
            gx = XW1'(cur.bx) + XW1'(cur.padding);
            gy = gy + sh;
        end
        glyph_ok = gy + sh <= bot;
`else
        glyph_ok = gy + sh <= bot && gx + sw <= right;
`endif
        dx = cur.cx + XW1'(pend.margin);
        child = pend;
        child.bx = cur.bx;
        child.by = cur.by;
        child.bw = cur.bw;
        child.bh = cur.bh;
        if (op_tag == `TAG_BODY) begin
            child.bx = '0;
            child.by = '0;
            child.bw = X_W'(SCREEN_W);
            child.bh = Y_W'(SCREEN_H);
        end else if (op_tag == `TAG_DIV) begin
            child.bx = X_W'(dx);
            child.by = Y_W'(cur.cy + YW1'(pend.margin));
            // An unsized div stretches to whatever the parent has left on the right.
            child.bw = pend.bw != '0 ? pend.bw :
                       dx < XW1'(cur.bx) + XW1'(cur.bw) ? X_W'(XW1'(cur.bx) + XW1'(cur.bw) - dx) : '0;
            child.bh = pend.bh;
        end
        child.cx = XW1'(child.bx) + XW1'(pend.padding);
        child.cy = YW1'(child.by) + YW1'(pend.padding);
        draw_rect = op_tag == `TAG_BODY || (op_tag == `TAG_DIV && pend.bw != '0 && pend.bh != '0);
        par = stk[top_i];
        par.cx = XW1'(par.bx) + XW1'(par.padding);
        par.cy = tag_stk[top_i] == `TAG_P ? cur.cy + sh :
                 tag_stk[top_i] == `TAG_DIV ? YW1'(cur.by) + YW1'(cur.bh) + YW1'(cur.margin) : par.cy;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            depth <= '0;
            dropped <= '0;
            err_overflow <= 1'b0;
            err_underflow <= 1'b0;
            rect_valid <= 1'b0;
            glyph_valid <= 1'b0;
            op_tag <= '0;
            cur <= root;
            pend <= root;
        end else begin
            case (state)
                IDLE: if (evt_valid) begin
                    case (evt_kind)
                        2'd0: case (evt_attr_type)
                            `ATT_COLOR: pend.color <= COLOR_W'(evt_attr_value);
                            `ATT_SIZE: pend.size <= evt_attr_value;
                            `ATT_WIDTH: pend.bw <= X_W'(evt_attr_value);
                            `ATT_HEIGHT: pend.bh <= Y_W'(evt_attr_value);
                            `ATT_BG: pend.bg <= COLOR_W'(evt_attr_value);
                            `ATT_MARGIN: pend.margin <= evt_attr_value;
                            `ATT_PADDING: pend.padding <= evt_attr_value;
                            `ATT_BORDER: begin
                                pend.border_en <= 1'b1;
                                pend.border_color <= COLOR_W'(evt_attr_value);
                            end
                            default: ;
                        endcase
                        2'd1: if (depth == DW'(STACK_DEPTH)) begin
                            err_overflow <= 1'b1;
                            dropped <= dropped + 1'b1;
                        end else begin
                            op_tag <= evt_tag;
                            state <= APPLY;
                        end
                        2'd2: if (dropped != '0) dropped <= dropped - 1'b1;
                            else if (depth == '0) err_underflow <= 1'b1;
                            else state <= POP;
                        default: if (evt_char >= 8'h20) begin
                            cur.cx <= gx;
                            cur.cy <= gy;
                            if (glyph_ok) begin
                                glyph_char <= evt_char;
                                glyph_x <= X_W'(gx);
                                glyph_y <= Y_W'(gy);
                                glyph_size <= cur.size;
                                glyph_color <= cur.color;
                                glyph_valid <= 1'b1;
                                state <= EMIT_GLYPH;
                            end
                        end
                    endcase
                end
                APPLY: begin
                    stk[depth] <= cur;
                    tag_stk[depth] <= op_tag;
                    cur <= child;
                    pend <= strip(child);
                    depth <= depth + 1'b1;
                    rect_x <= child.bx;
                    rect_y <= child.by;
                    rect_w <= child.bw;
                    rect_h <= child.bh;
                    rect_bg <= child.bg;
                    rect_border_color <= child.border_color;
                    rect_has_border <= child.border_en;
                    rect_valid <= draw_rect;
                    state <= draw_rect ? EMIT_RECT : IDLE;
                end
                EMIT_RECT: if (rect_ready) begin
                    rect_valid <= 1'b0;
                    state <= IDLE;
                end
                EMIT_GLYPH: if (glyph_ready) begin
                    glyph_valid <= 1'b0;
                    cur.cx <= cur.cx + adv;
                    state <= IDLE;
                end
                POP: begin
                    cur <= par;
                    pend <= strip(par);
                    depth <= depth - 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/html_layout_engine.md
Name: html_layout_engine

Overview:
- Parametrised successor to the single-context HTML draw sequencer.
- Consumes a stream of parsed markup events: attribute, open tag, close tag, character.
- Keeps a stack of style/box contexts, so closing a tag restores the parent style instead of resetting to defaults. Adds line wrapping and clipping.
- Issues rect and glyph draw commands over valid/ready handshakes to the existing render_rect and character_renderer stages.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour width
- VAL_W, 8, attribute value width
- STACK_DEPTH, 4, max nested open elements (>=1)
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- FONT_W, 5, glyph width
- FONT_H, 7, glyph height
- KERNING, 1, inter-glyph gap

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- evt_valid  in  1  event present
- evt_ready  out  1  event accepted when valid&ready
- evt_kind  in  2  0=attribute, 1=open tag end, 2=close tag, 3=char
- evt_tag  in  `ELE_TAG_BITES  tag code (`TAG_BODY/`TAG_P/`TAG_DIV)
- evt_attr_type  in  `ATTRIBUTE_TYPE_BITES  `ATT_* code
- evt_attr_value  in  VAL_W  attribute value
- evt_char  in  8  ASCII character
- rect_valid/rect_ready  out/in  1  rect command handshake
- rect_x, rect_y, rect_w, rect_h  out  X_W/Y_W/X_W/Y_W  box geometry
- rect_bg, rect_border_color  out  COLOR_W  colours
- rect_has_border  out  1  border enable
- glyph_valid/glyph_ready  out/in  1  glyph command handshake
- glyph_char  out  8  character
- glyph_x, glyph_y  out  X_W/Y_W  glyph origin
- glyph_size  out  VAL_W  scale
- glyph_color  out  COLOR_W  text colour
- depth  out  $clog2(STACK_DEPTH+1)  live stack depth
- err_overflow, err_underflow  out  1  sticky error flags

Behaviour:
- Context fields: color, size, box x/y/w/h, margin, padding, bg, border_en, border_color, cursor x/y.
- Root context after reset: color 7, size 1, box 0,0,SCREEN_W,SCREEN_H, everything else 0.
- Reset: all valids 0, evt_ready 0, depth 0, err flags 0, pending context = root. evt_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, APPLY, EMIT_RECT, EMIT_GLYPH, POP. evt_ready is high only in IDLE.
- Attribute event: consumed in 1 cycle, FSM stays IDLE. Writes the pending context:
  - COLOR, SIZE, WIDTH, HEIGHT, BG, MARGIN, PADDING: stored directly.
  - BORDER: sets border_en=1 and border_color=value.
  - Unknown type: ignored.
  - Value bits are truncated to the field width.
- Open event, IDLE->APPLY: push parent, top = pending.
  - BODY: box=0,0,SCREEN_W,SCREEN_H.
  - DIV: box x/y = parent cursor + margin; w/h from attributes; a zero w takes the parent's remaining width.
  - P: box = parent box.
  - Child cursor = box origin + padding.
  - BODY, and DIV with w,h both nonzero, go to EMIT_RECT; otherwise return to IDLE.
- Rect command: rect_valid asserts the cycle after APPLY. All rect_* outputs stay stable until rect_ready, then return to IDLE.
- Close event -> POP, 1 cycle: restore parent; parent cursor x = parent box x + parent padding.
  - P: parent cursor y = child cursor y + child size*FONT_H.
  - DIV: parent cursor y = div box y + h + margin.
  - Tag mismatch with the pushed tag still pops; no check.
  - After every open/close, pending is reloaded from the new top with margin/padding/w/h cleared.
- Char event: codes <0x20 are consumed with no glyph. Otherwise EMIT_GLYPH with glyph_valid the next cycle, held until glyph_ready; then cursor x += size*(FONT_W+KERNING).
- Arithmetic: performed in X_W+1 / Y_W+1 bits.
- Clipping: a glyph with cursor y + size*FONT_H > box bottom is suppressed (consumed, no glyph).
- Overflow: an open at depth==STACK_DEPTH is consumed with no push and no draw. It sets err_overflow and increments an internal dropped counter; each close decrements that counter first, with no pop.
- Underflow: a close at depth 0 with dropped==0 is ignored and sets err_underflow.
- Reset mid-handshake: valids drop the next cycle and the stack empties.

Optional Feature:
- LAYOUT_WRAP_EN defined: before emitting a glyph, if cursor x + size*FONT_W > box x + w - padding, then cursor x = box x + padding and cursor y += size*FONT_H. The clip check follows the wrap.
- Undefined: no wrap; a glyph crossing the right edge is suppressed (consumed, no glyph).

Test Plan:
- Reset, then chars 'A','B' -> glyphs (0,0,size1,color7) then (6,0); depth=0.
- Attrs color=4, size=2, open P, chars "AB", close P, char 'C' -> glyphs (0,0,c4,s2), (12,0,c4,s2), then 'C' at (0,14,c7,s1).
- Attrs width=40, height=20, bg=2, margin=4, border=1, open DIV, rect_ready held low 5 cycles -> rect 4,4,40,20,bg2,border1/color1 held stable with evt_ready=0. Then close DIV, char 'A' -> glyph (0,28).
- 27 chars at root, size1, LAYOUT_WRAP_EN defined -> char 25 at (150,0), char 26 at (0,7). Without the macro, char 26 produces no glyph and the next event is accepted.
- STACK_DEPTH=4, five opens of P -> depth=4, err_overflow=1. Five closes -> depth=0, err_underflow=0. A sixth close -> err_underflow=1.
- Reset asserted while glyph_valid=1 and glyph_ready=0 -> glyph_valid=0 the next cycle, depth=0, evt_ready=1 after release.
